// File: rtl/simplepiano_pkg.sv
// ---------------------------------------------------------------------------
// simplepiano_pkg
// Shared constants and helpers for the piano key front end.
//   NUM_KEYS        : keys in one octave (bit 11 = C / note 0 ... bit 0 = B / note 11)
//   NOTE_W / OCT_W  : widths of the note index and octave fields
//   SAMPLE_DIV_DEF  : default clocks per debounce sample tick
//   STABLE_N_DEF    : default consecutive equal samples for a debounced change
//   CNT_W           : tick counter width (covers SAMPLE_DIV up to 65535)
// ---------------------------------------------------------------------------
package simplepiano_pkg;

   localparam int NUM_KEYS       = 12;
   localparam int NOTE_W         = 4;
   localparam int OCT_W          = 3;
   localparam int SAMPLE_DIV_DEF = 1000;
   localparam int STABLE_N_DEF   = 4;
   localparam int CNT_W          = 16;

   typedef logic [NUM_KEYS-1:0] keyvec_t;

   // What the note selector does in a given cycle.
   typedef enum logic [1:0] {
      NA_NONE = 2'd0,
      NA_ON   = 2'd1,
      NA_OFF  = 2'd2
   } note_action_e;

   // Lowest note index present in v. Note 0 lives in the MSB, so the scan
   // starts at the top bit. Returns 0 for an empty vector (callers guard).
   function automatic logic [NOTE_W-1:0] lowest_note(input keyvec_t v);
      logic [NOTE_W-1:0] r;
      logic              found;
      r     = '0;
      found = 1'b0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i] && !found) begin
            r     = NOTE_W'(NUM_KEYS - 1 - i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// ---------------------------------------------------------------------------
// key_debounce_bit
// One key contact: 2-flop synchronizer, STABLE_N-deep sample history and the
// debounced output bit.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   key_raw  : asynchronous contact input
//   sample   : one-cycle strobe, shift the synchronized key into the history
//   update   : one-cycle strobe (cycle after sample), re-evaluate key_db
//   key_db   : debounced key level
// ---------------------------------------------------------------------------
module key_debounce_bit
   import simplepiano_pkg::*;
#(
   parameter int STABLE_N = STABLE_N_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   input  logic sample,
   input  logic update,
   output logic key_db
);

   logic                sync1_q;
   logic                sync2_q;
   logic [STABLE_N-1:0] hist_q, hist_d;
   logic                db_q, db_d;

   always_comb begin
      hist_d = hist_q;
      db_d   = db_q;
      if (sample) begin
         hist_d = {hist_q[STABLE_N-2:0], sync2_q};
      end
      // Mixed history means the contact is still bouncing: keep the old level.
      if (update) begin
         if (&hist_q) begin
            db_d = 1'b1;
         end else if (~|hist_q) begin
            db_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= '0;
         db_q    <= 1'b0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         hist_q  <= hist_d;
         db_q    <= db_d;
      end
   end

   assign key_db = db_q;

endmodule

// File: rtl/piano_key_frontend.sv
// ---------------------------------------------------------------------------
// piano_key_frontend
// Debounces 12 piano key contacts and turns them into a monophonic note stream
// with last-pressed priority.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   keys_raw   : asynchronous key contacts, bit 11 = C (note 0) .. bit 0 = B (note 11)
//   octave_raw : asynchronous octave select
//   keys_db    : debounced key vector
//   note_valid : a note is currently selected
//   note_idx   : selected note 0..11 (holds after the note ends)
//   note_oct   : octave captured when note_on fired
//   note_on    : one-cycle pulse when note_idx is (re)selected
//   note_off   : one-cycle pulse when note_valid falls
// ---------------------------------------------------------------------------
module piano_key_frontend
   import simplepiano_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int STABLE_N   = STABLE_N_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys_raw,
   input  logic [OCT_W-1:0]    octave_raw,
   output logic [NUM_KEYS-1:0] keys_db,
   output logic                note_valid,
   output logic [NOTE_W-1:0]   note_idx,
   output logic [OCT_W-1:0]    note_oct,
   output logic                note_on,
   output logic                note_off
);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [NOTE_W-1:0] KEY_LAST = NOTE_W'(NUM_KEYS - 1);

   logic [OCT_W-1:0]  oct_sync1_q, oct_sync2_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick;
   logic              tick_q;
   keyvec_t           db_w;
   keyvec_t           db_prev_q;
   keyvec_t           rise, fall;
   logic [NOTE_W-1:0] sel_pos;
   note_action_e      action;
   logic              valid_q, valid_d;
   logic [NOTE_W-1:0] idx_q, idx_d;
   logic [OCT_W-1:0]  oct_q, oct_d;
   logic              on_q, on_d;
   logic              off_q, off_d;

   // ---- sample tick: counter wraps at SAMPLE_DIV-1, tick_q marks the update cycle
   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         oct_sync1_q <= '0;
         oct_sync2_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         tick_q      <= tick;
         oct_sync1_q <= octave_raw;
         oct_sync2_q <= oct_sync1_q;
      end
   end

   // ---- per-key synchronizer / history / debounced bit
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce_bit #(
         .STABLE_N (STABLE_N)
      ) u_key (
         .clk     (clk),
         .rst     (rst),
         .key_raw (keys_raw[k]),
         .sample  (tick),
         .update  (tick_q),
         .key_db  (db_w[k])
      );
   end

   // ---- edge detect and note selection
   always_comb begin
      rise    = db_w & ~db_prev_q;
      fall    = ~db_w & db_prev_q;
      // Bit position of the selected note (note 0 sits in the MSB).
      sel_pos = KEY_LAST - idx_q;
      action  = NA_NONE;
      idx_d   = idx_q;
      valid_d = valid_q;
      oct_d   = oct_q;

      // A fresh press always wins, even if the selected key drops in the same cycle.
      if (|rise) begin
         action = NA_ON;
         idx_d  = lowest_note(rise);
      end else if (valid_q && fall[sel_pos]) begin
         if (|db_w) begin
            action = NA_ON;
            idx_d  = lowest_note(db_w);
         end else begin
            action = NA_OFF;
         end
      end

      on_d  = (action == NA_ON);
      off_d = (action == NA_OFF);
      if (action == NA_ON) begin
         valid_d = 1'b1;
         oct_d   = oct_sync2_q;
      end else if (action == NA_OFF) begin
         valid_d = 1'b0;
      end
   end

   // Reset clears the note state directly, so no note_off is produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_prev_q <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         oct_q     <= '0;
         on_q      <= 1'b0;
         off_q     <= 1'b0;
      end else begin
         db_prev_q <= db_w;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         oct_q     <= oct_d;
         on_q      <= on_d;
         off_q     <= off_d;
      end
   end

   assign keys_db    = db_w;
   assign note_valid = valid_q;
   assign note_idx   = idx_q;
   assign note_oct   = oct_q;
   assign note_on    = on_q;
   assign note_off   = off_q;

endmodule
